// File: rtl/stage2_pow2_approx.sv
//------------------------------------------------------------------------------
// Module      : stage2_pow2_approx
// Description : Second stage of the softmax approximation pipeline. Takes the
//               log2-stage outputs and computes d = in1 - log2(in0) in signed
//               Q(DW-FW).FW. It then evaluates 2^d with the Mitchell
//               piecewise-linear approximation 2^(I+F) ~= (1+F) << I. The
//               result is unsigned Q(DW-FW).FW.
//               The datapath is three registered stages under a global enable.
//               Latency is three enabled cycles.
// Ports       :
//   i_clk          in   clock, all state on the rising edge
//   i_rst          in   synchronous reset, active-high, priority over i_en
//   i_en           in   pipeline enable; low = every stage holds
//   i_valid        in   input sample valid
//   i_log2_in0     in   log2(in0), signed Q6.10 (0x8000 = log2 of zero)
//   i_in0_bypass   in   in0 forwarded from the log2 stage
//   i_in1_bypass   in   in1, signed Q6.10 exponent
//   o_valid        out  output valid
//   o_pow2         out  2^(in1 - log2(in0)), unsigned Q6.10
//   o_sat          out  o_pow2 clamped to all-ones for this sample
//   o_in0_bypass   out  i_in0_bypass aligned with o_pow2
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module stage2_pow2_approx #(
  parameter int DW = 16,
  parameter int FW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_valid,
  input  logic [DW-1:0] i_log2_in0,
  input  logic [DW-1:0] i_in0_bypass,
  input  logic [DW-1:0] i_in1_bypass,
  output logic          o_valid,
  output logic [DW-1:0] o_pow2,
  output logic          o_sat,
  output logic [DW-1:0] o_in0_bypass
);

  localparam int IW = DW - FW;  // integer bits of the fixed-point format

  localparam logic [DW-1:0] C_POS_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] C_NEG_MIN = {1'b1, {(DW-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Stage 0: input capture
  // ---------------------------------------------------------------------------
  logic          s0_valid_q;
  logic [DW-1:0] s0_log2_q;
  logic [DW-1:0] s0_in1_q;
  logic [DW-1:0] s0_in0_q;

  // ---------------------------------------------------------------------------
  // Stage 1: saturated difference
  // ---------------------------------------------------------------------------
  logic          s1_valid_q;
  logic [DW-1:0] s1_diff_q;
  logic          s1_pos_sat_q;
  logic [DW-1:0] s1_in0_q;

  logic [DW:0]   w_diff17;
  logic [DW-1:0] s1_diff_d;
  logic          s1_pos_sat_d;

  // ---------------------------------------------------------------------------
  // Stage 2: power-of-two approximation (output registers)
  // ---------------------------------------------------------------------------
  logic          s2_valid_q;
  logic [DW-1:0] s2_pow2_q;
  logic          s2_sat_q;
  logic [DW-1:0] s2_in0_q;

  logic [DW-1:0]      s2_pow2_d;
  logic               s2_sat_d;
  logic [IW-1:0]      w_int;
  logic signed [31:0] w_int_ext;
  logic [DW-1:0]      w_mant;

  // One extra bit holds the full range of the signed difference.
  assign w_diff17 = {s0_in1_q[DW-1], s0_in1_q} - {s0_log2_q[DW-1], s0_log2_q};

  // The top two bits of the widened difference disagree exactly when the
  // result does not fit in DW signed bits. The MSB gives the overflow direction.
  always_comb begin
    s1_diff_d    = w_diff17[DW-1:0];
    s1_pos_sat_d = 1'b0;
    if (w_diff17[DW] != w_diff17[DW-1]) begin
      if (w_diff17[DW]) begin
        s1_diff_d = C_NEG_MIN;
      end else begin
        s1_diff_d    = C_POS_MAX;
        s1_pos_sat_d = 1'b1;
      end
    end
  end

  // Split d into its integer part I (signed) and fractional part F.
  // The mantissa 1.F is placed in the low FW+1 bits. A left shift of up to
  // IW-1 therefore still fits in DW bits.
  assign w_int     = s1_diff_q[DW-1:FW];
  assign w_int_ext = {{(32-IW){w_int[IW-1]}}, w_int};
  assign w_mant    = {{(IW-1){1'b0}}, 1'b1, s1_diff_q[FW-1:0]};

  always_comb begin
    s2_pow2_d = '0;
    s2_sat_d  = 1'b0;
    if (s1_pos_sat_q || (w_int_ext >= IW)) begin
      s2_pow2_d = '1;
      s2_sat_d  = 1'b1;
    end else if (w_int_ext >= 0) begin
      s2_pow2_d = w_mant << w_int_ext;
    end else if (w_int_ext > -(FW + 1)) begin
      // Truncating right shift. Every set bit is shifted out below -FW.
      s2_pow2_d = w_mant >> (-w_int_ext);
    end else begin
      s2_pow2_d = '0;
    end
    // Bubbles never report saturation.
    if (!s1_valid_q) begin
      s2_sat_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s0_valid_q   <= 1'b0;
      s0_log2_q    <= '0;
      s0_in1_q     <= '0;
      s0_in0_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_diff_q    <= '0;
      s1_pos_sat_q <= 1'b0;
      s1_in0_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_pow2_q    <= '0;
      s2_sat_q     <= 1'b0;
      s2_in0_q     <= '0;
    end else if (i_en) begin
      s0_valid_q   <= i_valid;
      s0_log2_q    <= i_log2_in0;
      s0_in1_q     <= i_in1_bypass;
      s0_in0_q     <= i_in0_bypass;
      s1_valid_q   <= s0_valid_q;
      s1_diff_q    <= s1_diff_d;
      s1_pos_sat_q <= s1_pos_sat_d;
      s1_in0_q     <= s0_in0_q;
      s2_valid_q   <= s1_valid_q;
      s2_pow2_q    <= s2_pow2_d;
      s2_sat_q     <= s2_sat_d;
      s2_in0_q     <= s1_in0_q;
    end
  end

  assign o_valid      = s2_valid_q;
  assign o_pow2       = s2_pow2_q;
  assign o_sat        = s2_sat_q;
  assign o_in0_bypass = s2_in0_q;

endmodule

`default_nettype wire

// File: tb/tb_stage2_pow2_approx.sv
//------------------------------------------------------------------------------
// Module      : tb_stage2_pow2_approx
// Description : Directed self-checking bench for stage2_pow2_approx.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stage2_pow2_approx;

  logic        clk;
  logic        rst;
  logic        en;
  logic        valid;
  logic [15:0] log2_in0;
  logic [15:0] in0_bp;
  logic [15:0] in1_bp;
  logic        o_valid;
  logic [15:0] o_pow2;
  logic        o_sat;
  logic [15:0] o_in0_bypass;

  int total = 0;
  int bad   = 0;

  stage2_pow2_approx dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_valid      (valid),
    .i_log2_in0   (log2_in0),
    .i_in0_bypass (in0_bp),
    .i_in1_bypass (in1_bp),
    .o_valid      (o_valid),
    .o_pow2       (o_pow2),
    .o_sat        (o_sat),
    .o_in0_bypass (o_in0_bypass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vectors: in1, log2(in0), expected pow2, expected sat.
  localparam logic [15:0] VIN1 [12] = '{16'h0000, 16'h0400, 16'h0200, 16'h7C00,
                                        16'h1800, 16'h1400, 16'h8000, 16'hD400,
                                        16'hD800, 16'h17FF, 16'hFE00, 16'h0A00};
  localparam logic [15:0] VLOG [12] = '{16'h0000, 16'h0C00, 16'h0000, 16'h8000,
                                        16'h0000, 16'h0000, 16'h0400, 16'h0000,
                                        16'h0000, 16'h0000, 16'h0000, 16'h0200};
  localparam logic [15:0] VPOW [12] = '{16'h0400, 16'h0100, 16'h0600, 16'hFFFF,
                                        16'hFFFF, 16'h8000, 16'h0000, 16'h0000,
                                        16'h0001, 16'hFFE0, 16'h0300, 16'h1000};
  localparam logic        VSAT [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic drive(input logic r, input logic e, input logic v,
                       input logic [15:0] a1, input logic [15:0] lg,
                       input logic [15:0] b0);
    rst = r; en = e; valid = v; in1_bp = a1; log2_in0 = lg; in0_bp = b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 16'h1234, 16'h0000, 16'h5555);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", o_valid);
    end
    total++;
    if (o_pow2 !== 16'h0000) begin
      bad++; $display("FAIL reset_pow2: got %h want 0000", o_pow2);
    end
    total++;
    if (o_sat !== 1'b0) begin
      bad++; $display("FAIL reset_sat: got %b want 0", o_sat);
    end
    total++;
    if (o_in0_bypass !== 16'h0000) begin
      bad++; $display("FAIL reset_in0: got %h want 0000", o_in0_bypass);
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
  endtask

  task automatic test_pow2();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, VIN1[i], VLOG[i], 16'hB000 + 16'(i));
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      @(negedge clk);
      total++;
      if (o_valid !== 1'b0) begin
        bad++; $display("FAIL early_valid[%0d]: got %b want 0", i, o_valid);
      end
      @(negedge clk);
      total++;
      if (o_valid !== 1'b1) begin
        bad++; $display("FAIL vec_valid[%0d]: got %b want 1", i, o_valid);
      end
      total++;
      if (o_pow2 !== VPOW[i]) begin
        bad++; $display("FAIL vec_pow2[%0d]: got %h want %h", i, o_pow2, VPOW[i]);
      end
      total++;
      if (o_sat !== VSAT[i]) begin
        bad++; $display("FAIL vec_sat[%0d]: got %b want %b", i, o_sat, VSAT[i]);
      end
      total++;
      if (o_in0_bypass !== (16'hB000 + 16'(i))) begin
        bad++; $display("FAIL vec_in0[%0d]: got %h want %h", i, o_in0_bypass,
                        16'hB000 + 16'(i));
      end
    end
  endtask

  // Invalid samples that would saturate must come out as quiet bubbles.
  task automatic test_bubble();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h7C00, 16'h8000, 16'h1111);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (o_valid !== 1'b0) begin
        bad++; $display("FAIL bubble_valid[%0d]: got %b want 0", i, o_valid);
      end
      total++;
      if (o_sat !== 1'b0) begin
        bad++; $display("FAIL bubble_sat[%0d]: got %b want 0", i, o_sat);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
  endtask

  // Back-to-back stream with a two-cycle stall, then a reset with samples in
  // flight, then a fresh sample after the reset.
  task automatic test_back_to_back();
    logic        s_rst [15] = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0};
    logic        s_en  [15] = '{1,1,1,0,0,1,1,1,1,1,1,1,1,1,1};
    logic        s_vld [15] = '{1,1,1,1,1,1,1,1,1,1,0,1,0,0,0};
    logic [15:0] s_in1 [15] = '{16'h0000, 16'h0400, 16'h0800, 16'h0C00, 16'h0C00,
                                16'h0C00, 16'h1000, 16'h0200, 16'h0300, 16'h1400,
                                16'h0000, 16'hFE00, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] s_in0 [15] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA003,
                                16'hA003, 16'hA004, 16'hA005, 16'hA006, 16'hA007,
                                16'h0000, 16'hA008, 16'h0000, 16'h0000, 16'h0000};
    logic        e_vld [15] = '{0,0,1,1,1,1,1,1,1,0,0,0,0,1,0};
    logic [15:0] e_pow [15] = '{16'h0000, 16'h0000, 16'h0400, 16'h0400, 16'h0400,
                                16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h0000,
                                16'h0000, 16'h0000, 16'h0000, 16'h0300, 16'h0000};
    logic [15:0] e_in0 [15] = '{16'h0000, 16'h0000, 16'hA000, 16'hA000, 16'hA000,
                                16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'h0000,
                                16'h0000, 16'h0000, 16'h0000, 16'hA008, 16'h0000};
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(s_rst[i], s_en[i], s_vld[i], s_in1[i], 16'h0000, s_in0[i]);
      @(posedge clk);
      #1;
      total++;
      if (o_valid !== e_vld[i]) begin
        bad++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, o_valid, e_vld[i]);
      end
      if (e_vld[i]) begin
        total++;
        if (o_pow2 !== e_pow[i]) begin
          bad++; $display("FAIL b2b_pow2[%0d]: got %h want %h", i, o_pow2, e_pow[i]);
        end
        total++;
        if (o_in0_bypass !== e_in0[i]) begin
          bad++; $display("FAIL b2b_in0[%0d]: got %h want %h", i, o_in0_bypass,
                          e_in0[i]);
        end
        total++;
        if (o_sat !== 1'b0) begin
          bad++; $display("FAIL b2b_sat[%0d]: got %b want 0", i, o_sat);
        end
      end
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    test_reset();
    test_pow2();
    test_bubble();
    test_back_to_back();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
